// File: rtl/sb_rx_packet_deframer.sv
// USB4 sideband receive front end: line synchroniser, 10-bit symbol deserialiser and
// DLE/STX..DLE/ETX deframer with DLE de-stuffing.
module sb_rx_packet_deframer #(
  parameter logic [7:0]  DLE         = 8'hFE,
  parameter logic [7:0]  STX         = 8'h05,
  parameter logic [7:0]  ETX         = 8'h40,
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned IDLE_BITS   = 4
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbrx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_sop,
  output logic       rx_eop,
  output logic       rx_frame_err,
  output logic       rx_pkt_err,
  output logic       sbrx_idle
);

  localparam int unsigned CntW  = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);

  typedef enum logic [1:0] {SIdle, SData, SStop, SBreak} sym_state_e;
  typedef enum logic [1:0] {PHunt, PHuntDle, PPayload, PPayDle} pkt_state_e;

  // Synchroniser
  logic sync1_q, sbrx_s;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sbrx_s  <= 1'b1;
    end else begin
      sync1_q <= sbrx;
      sbrx_s  <= sync1_q;
    end
  end

  // Idle detector keeps running regardless of enable
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             sbrx_idle_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!sbrx_s) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleW'(IDLE_BITS)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_q  <= '0;
      sbrx_idle_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      sbrx_idle_q <= (idle_cnt_d == IdleW'(IDLE_BITS));
    end
  end

  // Symbol FSM
  sym_state_e sym_state_q, sym_state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] sym_byte_q, sym_byte_d;
  logic       sym_valid_q, sym_valid_d;
  logic       frame_err_q, frame_err_d;

  always_comb begin
    sym_state_d = sym_state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sym_byte_d  = sym_byte_q;
    sym_valid_d = 1'b0;
    frame_err_d = 1'b0;
    unique case (sym_state_q)
      SIdle: begin
        if (!sbrx_s) begin
          sym_state_d = SData;
          bit_cnt_d   = 3'd0;
        end
      end
      SData: begin
        shift_d = {sbrx_s, shift_q[7:1]};
        if (bit_cnt_q == 3'd7) begin
          sym_state_d = SStop;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      SStop: begin
        if (sbrx_s) begin
          sym_valid_d = 1'b1;
          sym_byte_d  = shift_q;
          sym_state_d = SIdle;
        end else begin
          frame_err_d = 1'b1;
          sym_state_d = SBreak;
        end
      end
      SBreak: begin
        if (sbrx_s) sym_state_d = SIdle;
      end
      default: sym_state_d = SIdle;
    endcase
    if (!enable) begin
      sym_state_d = SIdle;
      bit_cnt_d   = 3'd0;
      sym_valid_d = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      sym_state_q <= SIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      sym_byte_q  <= 8'h00;
      sym_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sym_state_q <= sym_state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sym_byte_q  <= sym_byte_d;
      sym_valid_q <= sym_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Packet FSM
  pkt_state_e      pkt_state_q, pkt_state_d;
  logic [CntW-1:0] pay_cnt_q, pay_cnt_d;
  logic            sop_pend_q, sop_pend_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            valid_q, valid_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            pkt_err_q, pkt_err_d;
  logic            emit;
  logic [7:0]      emit_data;

  always_comb begin
    pkt_state_d = pkt_state_q;
    pay_cnt_d   = pay_cnt_q;
    sop_pend_d  = sop_pend_q;
    rx_byte_d   = rx_byte_q;
    valid_d     = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    pkt_err_d   = 1'b0;
    emit        = 1'b0;
    emit_data   = sym_byte_q;

    if (frame_err_q) begin
      if (pkt_state_q == PPayload || pkt_state_q == PPayDle) pkt_err_d = 1'b1;
      pkt_state_d = PHunt;
    end else if (sym_valid_q) begin
      unique case (pkt_state_q)
        PHunt: begin
          if (sym_byte_q == DLE) pkt_state_d = PHuntDle;
        end
        PHuntDle: begin
          if (sym_byte_q == STX) begin
            pkt_state_d = PPayload;
            pay_cnt_d   = '0;
            sop_pend_d  = 1'b1;
          end else if (sym_byte_q != DLE) begin
            pkt_state_d = PHunt;
          end
        end
        PPayload: begin
          if (sym_byte_q == DLE) pkt_state_d = PPayDle;
          else emit = 1'b1;
        end
        PPayDle: begin
          if (sym_byte_q == DLE) begin
            pkt_state_d = PPayload;
            emit        = 1'b1;
            emit_data   = DLE;
          end else if (sym_byte_q == ETX) begin
            // An empty transaction is a protocol error, not an end of packet
            if (pay_cnt_q != '0) eop_d = 1'b1;
            else pkt_err_d = 1'b1;
            pkt_state_d = PHunt;
          end else if (sym_byte_q == STX) begin
            pkt_err_d   = 1'b1;
            pkt_state_d = PPayload;
            pay_cnt_d   = '0;
            sop_pend_d  = 1'b1;
          end else begin
            pkt_err_d   = 1'b1;
            pkt_state_d = PHunt;
          end
        end
        default: pkt_state_d = PHunt;
      endcase
    end

    if (emit) begin
      if (pay_cnt_q == CntW'(MAX_PAYLOAD)) begin
        pkt_err_d   = 1'b1;
        pkt_state_d = PHunt;
      end else begin
        valid_d    = 1'b1;
        rx_byte_d  = emit_data;
        sop_d      = sop_pend_q;
        sop_pend_d = 1'b0;
        pay_cnt_d  = pay_cnt_q + 1'b1;
      end
    end

    if (!enable) begin
      pkt_state_d = PHunt;
      pay_cnt_d   = '0;
      sop_pend_d  = 1'b0;
      rx_byte_d   = rx_byte_q;
      valid_d     = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      pkt_err_d   = 1'b0;
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      pkt_state_q <= PHunt;
      pay_cnt_q   <= '0;
      sop_pend_q  <= 1'b0;
      rx_byte_q   <= 8'h00;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      pkt_state_q <= pkt_state_d;
      pay_cnt_q   <= pay_cnt_d;
      sop_pend_q  <= sop_pend_d;
      rx_byte_q   <= rx_byte_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = valid_q;
  assign rx_sop        = sop_q;
  assign rx_eop        = eop_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_pkt_err    = pkt_err_q;
  assign sbrx_idle     = sbrx_idle_q;

endmodule

// File: doc/sb_rx_packet_deframer.md
# sb_rx_packet_deframer

Sideband receive front end of the USB4 logical layer. It sits directly downstream of the electrical-layer `sbrx` pin and upstream of the sideband transaction decoder. It synchronises the serial line, deserialises 10-bit symbols (start 0, 8 data bits LSB-first, stop 1) at one bit per `sb_clk`, and strips DLE/STX … DLE/ETX framing and DLE stuffing. It delivers payload bytes with start/end markers and error pulses.

## Interface
- `DLE`, 8'hFE, escape byte
- `STX`, 8'h05, start-of-transaction byte following DLE
- `ETX`, 8'h40, end-of-transaction byte following DLE
- `MAX_PAYLOAD`, 64, maximum de-stuffed payload bytes per transaction
- `IDLE_BITS`, 4, consecutive high bits needed to flag line idle
- `sb_clk`  in  1  sideband clock, one line bit per cycle
- `rst`  in  1  reset; one clock, and reset is asynchronous and active-low
- `enable`  in  1  receiver enable; low forces both FSMs to their idle state synchronously
- `sbrx`  in  1  asynchronous serial line, idle high
- `rx_byte`  out  8  de-stuffed payload byte
- `rx_byte_valid`  out  1  one-cycle pulse qualifying `rx_byte`
- `rx_sop`  out  1  high with the first `rx_byte_valid` of a transaction
- `rx_eop`  out  1  one-cycle pulse on DLE-ETX; `rx_byte_valid` is low in that cycle
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit is 0
- `rx_pkt_err`  out  1  one-cycle pulse on a framing-protocol violation
- `sbrx_idle`  out  1  level, line high for at least `IDLE_BITS` cycles

## Operation
- Synchroniser: two flops. Both reset to 1. Output is `sbrx_s`.
- Symbol FSM:
  - S_IDLE: `sbrx_s==0` goes to S_DATA with bit count 0.
  - S_DATA: shift in 8 bits LSB-first, then go to S_STOP.
  - S_STOP: if `sbrx_s==1`, pulse internal `sym_valid` with the byte and go to S_IDLE. If 0, pulse `rx_frame_err` and go to S_BREAK.
  - S_BREAK: wait for `sbrx_s==1`, then go to S_IDLE.
- Packet FSM runs on `sym_valid` and `rx_frame_err`:
  - P_HUNT: DLE goes to P_HUNT_DLE. Any other byte stays in P_HUNT.
  - P_HUNT_DLE: STX goes to P_PAYLOAD (count=0, sop pending). DLE stays in P_HUNT_DLE. Any other byte goes to P_HUNT.
  - P_PAYLOAD: DLE goes to P_PAY_DLE. Any other byte is emitted.
  - P_PAY_DLE: DLE emits data 8'hFE and returns to P_PAYLOAD. ETX handling is below. STX pulses `rx_pkt_err` and restarts P_PAYLOAD (count=0, sop pending). Any other byte pulses `rx_pkt_err` and goes to P_HUNT.
  - ETX in P_PAY_DLE with count>0: pulse `rx_eop` and go to P_HUNT.
  - ETX in P_PAY_DLE with count==0 (empty transaction): pulse `rx_pkt_err`, no `rx_eop`, and go to P_HUNT.
- Emit rule: if count==`MAX_PAYLOAD`, pulse `rx_pkt_err`, emit nothing and go to P_HUNT. Otherwise assert `rx_byte_valid`, assert `rx_sop` if sop pending, clear pending and increment count. Count width is clog2(`MAX_PAYLOAD`+1).
- `rx_frame_err` in P_PAYLOAD or P_PAY_DLE also pulses `rx_pkt_err` and goes to P_HUNT. In the hunt states it does not pulse `rx_pkt_err`.
- Idle counter: increments while `sbrx_s==1`, saturating at `IDLE_BITS`. It clears on `sbrx_s==0`. `sbrx_idle` = (count==`IDLE_BITS`), registered.
- `enable` low:
  - S_IDLE and P_HUNT are forced.
  - Count is cleared and sop pending is cleared.
  - All pulse outputs are 0.
  - The synchroniser and idle counter keep running.

## Timing
- Reset values:
  - All outputs are 0, including `rx_byte`=8'h00.
  - Synchroniser flops are 1.
  - Symbol FSM is S_IDLE and packet FSM is P_HUNT.
  - Counters are 0.
- Let a line bit be captured by flop 1 at edge k. That bit is in `sbrx_s` after edge k+1 and is consumed by the symbol FSM at edge k+2.
- Latency: stop bit captured at edge k produces `sym_valid`/`rx_frame_err` after edge k+2, and `rx_byte_valid`/`rx_eop`/`rx_pkt_err` after edge k+3.
- Back-to-back symbols, with the next start bit immediately after the stop bit, are accepted with no gap. The minimum output spacing is 10 cycles.
- `rx_frame_err` and the resulting `rx_pkt_err` appear in consecutive cycles.
- Asynchronous reset mid-symbol or mid-packet: return to reset values immediately. The partial transaction is discarded with no `rx_eop`.

## Test plan
- Reset, then line bytes FE 05 11 22 FE 40 -> `rx_byte` 11 with `rx_sop`, then 22, then `rx_eop`. No errors. Each output lands 3 edges after its stop bit is captured.
- Stuffing: FE 05 FE FE 33 FE 40 -> bytes FE (with sop) and 33, then `rx_eop`. Separately, FE 05 FE 40 -> `rx_pkt_err`, no `rx_eop`.
- Stop bit forced 0 on the 2nd payload symbol -> `rx_frame_err`, then `rx_pkt_err`, no `rx_eop`. The following valid transaction FE 05 AA FE 40 is received normally.
- 65 non-DLE payload bytes -> 64 `rx_byte_valid` pulses, `rx_pkt_err` on the 65th, no 65th byte. The trailing FE 40 produces no `rx_eop`.
- FE 05 01 FE 77 -> `rx_pkt_err`, then return to hunt. FE 05 01 FE 05 02 FE 40 -> 01 (sop), `rx_pkt_err`, 02 (sop), `rx_eop`.
- Line held high 4 cycles -> `sbrx_idle`=1. Then:
  - `rst` low mid-symbol -> all outputs 0 immediately.
  - `enable` low mid-payload -> no further outputs. After re-enable, only a new DLE STX starts a transaction.
